// File: rtl/gessm_pkg.sv
// Shared constants and types for the gESSM approximate multiplier (n=16, m=8, q=7).
// Segment selection yields an 8-bit slice plus the left shift that restores its weight.
package gessm_pkg;

    localparam int N = 16;
    localparam int M = 8;
    localparam int Q = 7;

    localparam logic [3:0] SH_HI  = 4'd8;
    localparam logic [3:0] SH_MID = 4'd7;
    localparam logic [3:0] SH_LO  = 4'd0;

    typedef struct packed {
        logic [M-1:0] xs;
        logic [3:0]   sh;
    } seg_t;

endpackage

// File: rtl/gessm_seg.sv
// Combinational operand segmentation: picks the 8-bit window holding the leading one
// (top byte, bits 14:7, or low byte) and reports the shift that undoes the selection.
module gessm_seg
    import gessm_pkg::*;
(
    input  logic [N-1:0] x,
    output seg_t         seg
);

    // NOTE: every field gets a default first so no path through the block can infer a latch.
    always_comb begin
        seg.xs = x[M-1:0];
        seg.sh = SH_LO;
        if (x[N-1]) begin
            seg.xs = x[N-1:N-M];
            seg.sh = SH_HI;
        end else if (|x[N-2:N-M]) begin
            seg.xs = x[N-2:N-M-1];
            seg.sh = SH_MID;
        end
    end

endmodule

// File: rtl/gessm_mul_sched.sv
// Round-robin scheduler feeding a three-stage gESSM approximate multiplier shared by
// NREQ requesters; results return in grant order tagged with the requester index.
module gessm_mul_sched
    import gessm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N-1:0]       out_ris,
    output logic [IDW-1:0]       out_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           adv;
    logic           accept;
    logic [N-1:0]   a_sel;
    logic [N-1:0]   b_sel;
    seg_t           seg_a;
    seg_t           seg_b;

    logic           s1_valid;
    logic [M-1:0]   s1_as;
    logic [M-1:0]   s1_bs;
    logic [3:0]     s1_sa;
    logic [3:0]     s1_sb;
    logic [IDW-1:0] s1_id;

    logic           s2_valid;
    logic [2*M-1:0] s2_mssm;
    logic [4:0]     s2_sh;
    logic [IDW-1:0] s2_id;

    // The whole pipeline moves as one: it advances only when the output slot frees up.
    assign adv = !out_valid || out_ready;

    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
    end

    // Reset gating keeps req_ready low while rst is held, even though adv is high then.
    assign accept = grant_found && adv && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign a_sel = req_a[int'(grant_idx)*N +: N];
    assign b_sel = req_b[int'(grant_idx)*N +: N];

    gessm_seg u_seg_a (.x(a_sel), .seg(seg_a));
    gessm_seg u_seg_b (.x(b_sel), .seg(seg_b));

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's pre-edge value and the pipeline shifts by exactly one step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            if (int'(grant_idx) == NREQ - 1) ptr <= '0;
            else                             ptr <= grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_as     <= '0;
            s1_bs     <= '0;
            s1_sa     <= '0;
            s1_sb     <= '0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_mssm   <= '0;
            s2_sh     <= '0;
            s2_id     <= '0;
            out_valid <= 1'b0;
            out_ris   <= '0;
            out_id    <= '0;
        end else if (adv) begin
            s1_valid  <= accept;
            s1_as     <= seg_a.xs;
            s1_bs     <= seg_b.xs;
            s1_sa     <= seg_a.sh;
            s1_sb     <= seg_b.sh;
            s1_id     <= grant_idx;

            s2_valid  <= s1_valid;
            s2_mssm   <= s1_as * s1_bs;
            s2_sh     <= {1'b0, s1_sa} + {1'b0, s1_sb};
            s2_id     <= s1_id;

            out_valid <= s2_valid;
            out_ris   <= {{(2*N-2*M){1'b0}}, s2_mssm} << s2_sh;
            out_id    <= s2_id;
        end
    end

endmodule

// File: tb/tb_gessm_mul_sched.sv
// Directed self-checking bench for gessm_mul_sched: latency, segmentation cases,
// round-robin order, backpressure freeze and mid-flight reset.
module tb_gessm_mul_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_ris;
    logic [IDW-1:0]   out_id;

    int checks = 0;
    int errors = 0;

    // Products of the small operand set a_i = i+3, b_i = i+5 (exact, no segmentation loss).
    logic [31:0] small_prod [NREQ] = '{32'd15, 32'd24, 32'd35, 32'd48};

    gessm_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ris   (out_ris),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge, away from the sampling point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic set_small_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 3), 16'(i + 5));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state, with a request already pending.
        set_op(0, 16'h00FF, 16'h00FF);
        req_valid = 4'b0001;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_ris",   out_ris,        32'h0);
        check("rst_out_id",    32'(out_id),    32'h0);

        // 0x00FF * 0x00FF from requester 0, three edges from accept to output.
        rst = 1'b0;
        #1;
        check("t1_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        check("t1_lat1", 32'(out_valid), 32'h0);
        step();
        check("t1_lat2", 32'(out_valid), 32'h0);
        step();
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_ris",   out_ris,        32'h0000FE01);
        check("t1_id",    32'(out_id),    32'h0);
        step();
        check("t1_drain", 32'(out_valid), 32'h0);

        // 0x8000 * 0x0002 from requester 2 (ptr=1, scan reaches 2).
        set_op(2, 16'h8000, 16'h0002);
        req_valid = 4'b0100;
        #1;
        check("t2_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();
        step();
        check("t2_valid", 32'(out_valid), 32'h1);
        check("t2_ris",   out_ris,        32'h00010000);
        check("t2_id",    32'(out_id),    32'h2);

        // 0x4321 * 0x1234 from requester 1 (ptr=3, scan wraps 3,0,1).
        set_op(1, 16'h4321, 16'h1234);
        req_valid = 4'b0010;
        #1;
        check("t3_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        step();
        check("t3_valid", 32'(out_valid), 32'h1);
        check("t3_ris",   out_ris,        32'h04B60000);
        check("t3_id",    32'(out_id),    32'h1);
        step();
        check("t3_drain", 32'(out_valid), 32'h0);

        // Backpressure: ptr=2, fill the pipeline with results 2,3,0 then stall 5 cycles.
        set_small_ops();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("bp_grant0", 32'(req_ready), 32'b0100);
        step();
        check("bp_grant1", 32'(req_ready), 32'b1000);
        step();
        check("bp_grant2", 32'(req_ready), 32'b0001);
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_ready0", 32'(req_ready), 32'h0);
            check("bp_valid",  32'(out_valid), 32'h1);
            check("bp_ris",    out_ris,        small_prod[2]);
            check("bp_id",     32'(out_id),    32'h2);
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        check("bp_rel_ris", out_ris,     small_prod[2]);
        check("bp_rel_id",  32'(out_id), 32'h2);
        step();
        check("bp_r1_valid", 32'(out_valid), 32'h1);
        check("bp_r1_ris",   out_ris,        small_prod[3]);
        check("bp_r1_id",    32'(out_id),    32'h3);
        step();
        check("bp_r2_valid", 32'(out_valid), 32'h1);
        check("bp_r2_ris",   out_ris,        small_prod[0]);
        check("bp_r2_id",    32'(out_id),    32'h0);
        step();
        check("bp_empty", 32'(out_valid), 32'h0);

        // Reset with three results in flight (ptr=1: grants 1,2,3).
        req_valid = 4'b1111;
        #1;
        check("rs_grant", 32'(req_ready), 32'b0010);
        step();
        step();
        step();
        req_valid = '0;
        check("rs_pre_valid", 32'(out_valid), 32'h1);
        check("rs_pre_id",    32'(out_id),    32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_valid", 32'(out_valid), 32'h0);
        check("rs_async_ris",   out_ris,        32'h0);
        check("rs_async_id",    32'(out_id),    32'h0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rs_no_stale", 32'(out_valid), 32'h0);
            step();
        end

        // Round robin from ptr=0 with all requesters active: one grant and one result per cycle.
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 9; i++) begin
            check("rr_grant", 32'(req_ready), 32'(1 << (i % NREQ)));
            if (i >= 3) begin
                check("rr_valid", 32'(out_valid), 32'h1);
                check("rr_id",    32'(out_id),    32'((i - 3) % NREQ));
                check("rr_ris",   out_ris,        small_prod[(i - 3) % NREQ]);
            end
            step();
        end
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
